// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//
// Serial frame receiver with even-parity check. A frame is DATA_W data bits,
// MSB first, followed by one parity bit. The first data bit is marked by
// in_start. The decoded frame is held on the outputs until the downstream
// handshake completes.
//
// Parameters
//   DATA_W       data bits per frame (1..32)
//
// Ports
//   clk          clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   in_valid     serial bit present on in_bit
//   in_bit       serial frame bit
//   in_start     marks the accepted bit as the first data bit of a frame
//   in_ready     block can accept a bit this cycle (registered)
//   out_valid    decoded frame is held on out_data / out_par_err
//   out_ready    downstream accepts the frame
//   out_data     received data, first received bit at MSB
//   out_par_err  parity mismatch for the held frame
//   err_cnt      delivered frames with parity error, saturating at 255
//
// Build option
//   PARITY_ERR_COUNT_EN  when defined, err_cnt counts delivered frames with a
//                        parity error; when undefined, err_cnt is tied to 0.
// -----------------------------------------------------------------------------
module parity_frame_rx #(
   parameter int unsigned DATA_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              in_start,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par_err,
   output logic [7:0]        err_cnt
);

   // Counter wide enough to hold the value DATA_W.
   localparam int unsigned CntW = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StHold
   } state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_par_err_q;

   logic beat;
   logic handshake;

   // in_ready_q is low in HOLD, so a beat can only happen in IDLE/DATA/PARITY.
   assign beat      = in_valid & in_ready_q;
   assign handshake = out_valid_q & out_ready;

   // Receive FSM with registered handshake and frame outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         shift_q       <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_par_err_q <= 1'b0;
      end else begin
         // Ready rises on the first edge after reset and whenever we are not holding.
         in_ready_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (beat && in_start) begin
                  shift_q <= DATA_W'(in_bit);
                  cnt_q   <= CntW'(1);
                  state_q <= (DATA_W == 1) ? StParity : StData;
               end
            end

            StData: begin
               if (beat) begin
                  if (in_start) begin
                     // Restart: drop partial data, this bit is the new MSB.
                     shift_q <= DATA_W'(in_bit);
                     cnt_q   <= CntW'(1);
                     state_q <= (DATA_W == 1) ? StParity : StData;
                  end else begin
                     shift_q <= (shift_q << 1) | DATA_W'(in_bit);
                     cnt_q   <= cnt_q + CntW'(1);
                     if (cnt_q == LastCnt) begin
                        state_q <= StParity;
                     end
                  end
               end
            end

            StParity: begin
               if (beat) begin
                  if (in_start) begin
                     shift_q <= DATA_W'(in_bit);
                     cnt_q   <= CntW'(1);
                     state_q <= (DATA_W == 1) ? StParity : StData;
                  end else begin
                     // Even parity: error when data XOR parity bit is 1.
                     out_data_q    <= shift_q;
                     out_par_err_q <= (^shift_q) ^ in_bit;
                     out_valid_q   <= 1'b1;
                     in_ready_q    <= 1'b0;
                     cnt_q         <= '0;
                     state_q       <= StHold;
                  end
               end
            end

            StHold: begin
               in_ready_q <= 1'b0;
               if (handshake) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef PARITY_ERR_COUNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else if (handshake && out_par_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_par_err = out_par_err_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

   localparam int unsigned DW = 3;

`ifdef PARITY_ERR_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_bit;
   logic          in_start;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_par_err;
   logic [7:0]    err_cnt;

   parity_frame_rx #(.DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_start    (in_start),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_par_err (out_par_err),
      .err_cnt     (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Expected frames: {data, par_err}.
   logic [DW:0] exp_q[$];
   int          err_exp = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: compare at every output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[DW:1]));
            check("out_par_err", 32'(out_par_err), 32'(e[0]));
            if (CntEn && e[0] && err_exp < 255) err_exp++;
         end
      end
   end

   task automatic send_bit(input logic b, input logic s);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_bit   = b;
      in_start = s;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("beat_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_start = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic p);
      for (int i = DW - 1; i >= 0; i--) send_bit(d[i], (i == DW - 1));
      exp_q.push_back({d, (^d) ^ p});
      send_bit(p, 1'b0);
      check("valid_latency", 32'(out_valid), 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_start  = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // Beats without start in IDLE are discarded.
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);

      // Good frame 101, parity 0.
      send_frame(3'b101, 1'b0);
      wait_drain();
      check("data_kept_after", 32'(out_data), 32'h5);
      check("valid_dropped", 32'(out_valid), 32'd0);

      // Error frame 001, parity 0.
      send_frame(3'b001, 1'b0);
      wait_drain();
      check("err_cnt_one", 32'(err_cnt), 32'(err_exp));

      // Hold with out_ready low; extra beats must be ignored.
      out_ready = 1'b0;
      send_frame(3'b110, 1'b0);
      in_valid = 1'b1;
      in_start = 1'b1;
      in_bit   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'h6);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      in_start = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Restart mid-frame: only the restarted frame is delivered.
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_frame(3'b010, 1'b1);
      wait_drain();

      // Restart in PARITY state.
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_frame(3'b111, 1'b1);
      wait_drain();

      // Reset mid-frame.
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      err_exp = 0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_par_err", 32'(out_par_err), 32'd0);
      check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // A stray parity-like bit must not complete the abandoned frame.
      send_bit(1'b1, 1'b0);
      send_frame(3'b011, 1'b0);
      wait_drain();
      check("post_rst_err_cnt", 32'(err_cnt), 32'(err_exp));

      // Random frames, random out_ready stalls.
      for (int k = 0; k < 20; k++) begin
         logic [DW-1:0] d;
         d = DW'($urandom_range(0, 7));
         out_ready = 1'($urandom_range(0, 1));
         send_frame(d, 1'($urandom_range(0, 1)));
         @(negedge clk);
         out_ready = 1'b1;
         wait_drain();
      end
      check("rand_err_cnt", 32'(err_cnt), 32'(err_exp));

      // 260 error frames: counter saturates when enabled.
      for (int k = 0; k < 260; k++) begin
         send_frame(3'b100, 1'b0);
         wait_drain();
      end
      check("sat_err_cnt", 32'(err_cnt), CntEn ? 32'd255 : 32'd0);
      check("sat_model", 32'(err_cnt), 32'(err_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      check("global_timeout", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
